// File: rtl/stack_engine_pkg.sv
// ============================================================================
// Module      : stack_pkg
// Description : Shared opcodes, FSM states and page constant for stack_engine.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package stack_pkg;

  localparam logic [7:0] STACK_PAGE = 8'h01;

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_PUSH   = 2'd1,
    OP_PULL   = 2'd2,
    OP_LOADSP = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PUSH      = 3'd1,
    PULL_ADDR = 3'd2,
    PULL_LAST = 3'd3,
    DONE      = 3'd4
  } state_e;

  // A zero length request behaves like a single-byte access.
  function automatic logic [1:0] eff_len(input logic [1:0] len);
    return (len == 2'd0) ? 2'd1 : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stack_engine_if.sv
// ============================================================================
// Module      : stack_engine_if
// Description : Command, response and page-1 memory bus of the stack engine.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface stack_engine_if;
  import stack_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  op_e         cmd_op;
  logic [1:0]  cmd_len;
  logic [23:0] cmd_wdata;
  logic [7:0]  cmd_sp;
  logic        rsp_done;
  logic [23:0] rsp_rdata;
  logic [7:0]  sp;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_wdata, cmd_sp, mem_rdata,
    input  cmd_ready, rsp_done, rsp_rdata, sp, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_wdata, cmd_sp, mem_rdata,
    output cmd_ready, rsp_done, rsp_rdata, sp, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/stack_engine.sv
// ============================================================================
// Module      : stack_engine
// Description : 6502 stack pointer owner; multi-byte push/pull on page 1.
//               Optional sticky wrap flag built with STACK_WRAP_DETECT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module stack_engine
  import stack_pkg::*;
#(
  parameter logic [7:0] SP_RESET = 8'hFF
) (
  input  logic        ph1,
  input  logic        reset,
  stack_engine_if.slave bus
`ifdef STACK_WRAP_DETECT_EN
  ,
  output logic        sp_fault
`endif
);

  state_e      state;
  logic [7:0]  s;
  logic [1:0]  cnt;
  logic [1:0]  cap;
  logic        pend;
  logic [15:0] wbuf;
  logic        cmd_ready;
  logic        rsp_done;
  logic [23:0] rsp_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        accept;

  assign accept        = (state == IDLE) && bus.cmd_valid && cmd_ready;
  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_done  = rsp_done;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.sp        = s;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  always_ff @(posedge ph1) begin
    if (reset) begin
      state     <= IDLE;
      s         <= SP_RESET;
      cnt       <= 2'd0;
      cap       <= 2'd0;
      pend      <= 1'b0;
      wbuf      <= 16'h0000;
      cmd_ready <= 1'b1;
      rsp_done  <= 1'b0;
      rsp_rdata <= 24'h000000;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {STACK_PAGE, 8'h00};
      mem_wdata <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            rsp_rdata <= 24'h000000;
            cap       <= 2'd0;
            pend      <= 1'b0;
            cnt       <= eff_len(bus.cmd_len);
            case (bus.cmd_op)
              OP_PUSH: begin
                state     <= PUSH;
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= {STACK_PAGE, s};
                mem_wdata <= bus.cmd_wdata[23:16];
                wbuf      <= bus.cmd_wdata[15:0];
              end
              OP_PULL: begin
                state    <= PULL_ADDR;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= {STACK_PAGE, s + 8'd1};
              end
              OP_LOADSP: begin
                s        <= bus.cmd_sp;
                state    <= DONE;
                rsp_done <= 1'b1;
              end
              default: begin
                state    <= DONE;
                rsp_done <= 1'b1;
              end
            endcase
          end
        end
        PUSH: begin
          s <= s - 8'd1;
          if (cnt > 2'd1) begin
            cnt       <= cnt - 2'd1;
            mem_addr  <= {STACK_PAGE, s - 8'd1};
            mem_wdata <= wbuf[15:8];
            wbuf      <= {wbuf[7:0], 8'h00};
          end else begin
            state    <= DONE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            rsp_done <= 1'b1;
          end
        end
        PULL_ADDR: begin
          s    <= s + 8'd1;
          pend <= 1'b1;
          // Data for the previous read arrives while the next one is issued.
          if (pend) begin
            rsp_rdata[{cap, 3'b000} +: 8] <= bus.mem_rdata;
            cap <= cap + 2'd1;
          end
          if (cnt > 2'd1) begin
            cnt      <= cnt - 2'd1;
            mem_addr <= {STACK_PAGE, s + 8'd2};
          end else begin
            state   <= PULL_LAST;
            mem_req <= 1'b0;
          end
        end
        PULL_LAST: begin
          rsp_rdata[{cap, 3'b000} +: 8] <= bus.mem_rdata;
          state    <= DONE;
          rsp_done <= 1'b1;
        end
        DONE: begin
          rsp_done  <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          rsp_done  <= 1'b0;
          cmd_ready <= 1'b1;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

`ifdef STACK_WRAP_DETECT_EN
  logic fault;
  assign sp_fault = fault;

  always_ff @(posedge ph1) begin
    if (reset) begin
      fault <= 1'b0;
    end else if (accept && (bus.cmd_op == OP_LOADSP)) begin
      fault <= 1'b0;
    end else if ((state == PUSH && s == 8'h00) || (state == PULL_ADDR && s == 8'hFF)) begin
      fault <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_stack_engine.sv
// ============================================================================
// Module      : tb_stack_engine
// Description : Directed self-checking bench for stack_engine with page-1 memory.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_stack_engine;
  import stack_pkg::*;

  logic ph1;
  logic reset;
  stack_engine_if bus();
`ifdef STACK_WRAP_DETECT_EN
  logic sp_fault;
`endif

  stack_engine #(.SP_RESET(8'hFF)) dut (
    .ph1      (ph1),
    .reset    (reset),
    .bus      (bus.slave)
`ifdef STACK_WRAP_DETECT_EN
    ,
    .sp_fault (sp_fault)
`endif
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  logic [7:0] mem [256];
  int writes;
  int vectors;
  int errors;

  // Page-1 memory: writes land at the edge, read data is valid the next cycle.
  always @(posedge ph1) begin
    if (bus.mem_req && bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      writes <= writes + 1;
    end
    if (bus.mem_req && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    else                            bus.mem_rdata <= 8'h00;
  end

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input op_e op, input logic [1:0] len, input logic [23:0] wd, input logic [7:0] spv);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = len;
    bus.cmd_wdata = wd;
    bus.cmd_sp    = spv;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input logic [15:0] addr, input logic [7:0] data);
    chk({tag, "_req"},  {31'd0, bus.mem_req}, 32'd1);
    chk({tag, "_we"},   {31'd0, bus.mem_we},  32'd1);
    chk({tag, "_addr"}, {16'd0, bus.mem_addr}, {16'd0, addr});
    chk({tag, "_data"}, {24'd0, bus.mem_wdata}, {24'd0, data});
  endtask

  task automatic chk_rd(input string tag, input logic [15:0] addr);
    chk({tag, "_req"},  {31'd0, bus.mem_req}, 32'd1);
    chk({tag, "_we"},   {31'd0, bus.mem_we},  32'd0);
    chk({tag, "_addr"}, {16'd0, bus.mem_addr}, {16'd0, addr});
  endtask

  int wc0;

  initial begin
    vectors = 0;
    errors  = 0;
    writes  = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_len   = 2'd0;
    bus.cmd_wdata = 24'h0;
    bus.cmd_sp    = 8'h0;
    reset = 1'b1;
    tick();
    tick();

    chk("rst_sp",     {24'd0, bus.sp}, 32'hFF);
    chk("rst_ready",  {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_req",    {31'd0, bus.mem_req}, 32'd0);
    chk("rst_done",   {31'd0, bus.rsp_done}, 32'd0);
    chk("rst_addr",   {16'd0, bus.mem_addr}, 32'h0100);
    chk("rst_rdata",  {8'd0, bus.rsp_rdata}, 32'd0);
`ifdef STACK_WRAP_DETECT_EN
    chk("rst_fault",  {31'd0, sp_fault}, 32'd0);
`endif
    reset = 1'b0;
    tick();

    // LOADSP 0xFD
    issue(OP_LOADSP, 2'd0, 24'h0, 8'hFD);
    chk("ld_done", {31'd0, bus.rsp_done}, 32'd1);
    chk("ld_sp",   {24'd0, bus.sp}, 32'hFD);
    tick();
    chk("ld_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // PUSH 3 bytes 12 34 56
    issue(OP_PUSH, 2'd3, 24'h123456, 8'h00);
    chk_wr("p3_w1", 16'h01FD, 8'h12);
    chk("p3_busy", {31'd0, bus.cmd_ready}, 32'd0);
    tick();
    chk_wr("p3_w2", 16'h01FC, 8'h34);
    chk("p3_sp2", {24'd0, bus.sp}, 32'hFC);
    tick();
    chk_wr("p3_w3", 16'h01FB, 8'h56);
    tick();
    chk("p3_done", {31'd0, bus.rsp_done}, 32'd1);
    chk("p3_req",  {31'd0, bus.mem_req}, 32'd0);
    chk("p3_sp",   {24'd0, bus.sp}, 32'hFA);
    chk("p3_rd0",  {8'd0, bus.rsp_rdata}, 32'd0);
    tick();
    chk("p3_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("p3_done0", {31'd0, bus.rsp_done}, 32'd0);

    // PULL 3 bytes
    issue(OP_PULL, 2'd3, 24'h0, 8'h00);
    chk_rd("l3_r1", 16'h01FB);
    chk("l3_sp1", {24'd0, bus.sp}, 32'hFA);
    tick();
    chk_rd("l3_r2", 16'h01FC);
    chk("l3_sp2", {24'd0, bus.sp}, 32'hFB);
    tick();
    chk_rd("l3_r3", 16'h01FD);
    tick();
    chk("l3_req4",  {31'd0, bus.mem_req}, 32'd0);
    chk("l3_done4", {31'd0, bus.rsp_done}, 32'd0);
    tick();
    chk("l3_done",  {31'd0, bus.rsp_done}, 32'd1);
    chk("l3_rdata", {8'd0, bus.rsp_rdata}, 32'h123456);
    chk("l3_sp",    {24'd0, bus.sp}, 32'hFD);
    tick();

    // Wrap: LOADSP 0x00, PUSH 2 bytes 22 33
    issue(OP_LOADSP, 2'd0, 24'h0, 8'h00);
    tick();
    issue(OP_PUSH, 2'd2, 24'h223300, 8'h00);
    chk_wr("wr_w1", 16'h0100, 8'h22);
    tick();
    chk_wr("wr_w2", 16'h01FF, 8'h33);
    chk("wr_sp2", {24'd0, bus.sp}, 32'hFF);
    tick();
    chk("wr_done", {31'd0, bus.rsp_done}, 32'd1);
    chk("wr_sp",   {24'd0, bus.sp}, 32'hFE);
`ifdef STACK_WRAP_DETECT_EN
    chk("wr_fault", {31'd0, sp_fault}, 32'd1);
`endif
    tick();
    issue(OP_LOADSP, 2'd0, 24'h0, 8'hFE);
`ifdef STACK_WRAP_DETECT_EN
    chk("wr_fault_clr", {31'd0, sp_fault}, 32'd0);
`endif
    tick();

    // PHA / PLA round trip from sp=0xFE
    issue(OP_PUSH, 2'd1, 24'h220000, 8'h00);
    chk_wr("pha_w", 16'h01FE, 8'h22);
    tick();
    chk("pha_done", {31'd0, bus.rsp_done}, 32'd1);
    chk("pha_sp",   {24'd0, bus.sp}, 32'hFD);
    tick();
    issue(OP_PULL, 2'd1, 24'h0, 8'h00);
    chk_rd("pla_r", 16'h01FE);
    tick();
    chk("pla_req", {31'd0, bus.mem_req}, 32'd0);
    tick();
    chk("pla_done",  {31'd0, bus.rsp_done}, 32'd1);
    chk("pla_rdata", {8'd0, bus.rsp_rdata}, 32'h000022);
    chk("pla_sp",    {24'd0, bus.sp}, 32'hFE);
    tick();

    // Length 0 behaves as a single byte
    issue(OP_PUSH, 2'd0, 24'h5A0000, 8'h00);
    chk_wr("l0_w", 16'h01FE, 8'h5A);
    tick();
    chk("l0_done", {31'd0, bus.rsp_done}, 32'd1);
    chk("l0_sp",   {24'd0, bus.sp}, 32'hFD);
    tick();

    // Busy push with cmd_valid held, then reset after the second write
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_PUSH;
    bus.cmd_len   = 2'd3;
    bus.cmd_wdata = 24'hAABBCC;
    tick();
    chk_wr("bz_w1", 16'h01FD, 8'hAA);
    chk("bz_busy1", {31'd0, bus.cmd_ready}, 32'd0);
    tick();
    chk_wr("bz_w2", 16'h01FC, 8'hBB);
    chk("bz_busy2", {31'd0, bus.cmd_ready}, 32'd0);
    wc0 = writes;
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("bz_rst_req",   {31'd0, bus.mem_req}, 32'd0);
    chk("bz_rst_done",  {31'd0, bus.rsp_done}, 32'd0);
    chk("bz_rst_sp",    {24'd0, bus.sp}, 32'hFF);
    chk("bz_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    chk("bz_done_a", {31'd0, bus.rsp_done}, 32'd0);
    chk("bz_req_a",  {31'd0, bus.mem_req}, 32'd0);
    tick();
    chk("bz_done_b", {31'd0, bus.rsp_done}, 32'd0);
    chk("bz_writes", writes, wc0 + 1);
    chk("bz_mem_fb", {24'd0, mem[8'hFB]}, 32'h56);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stack_engine.md
# stack_engine

Sequencer that owns the 6502 stack pointer S and performs multi-byte pushes and pulls on page 1 (0x0100–0x01FF). The controller issues one command for each stack event:
- PHA/PHP: 1-byte push.
- JSR: 2-byte push.
- BRK/IRQ/NMI: 3-byte push.
- PLA/PLP: 1-byte pull.
- RTS: 2-byte pull.
- RTI: 3-byte pull.

It also services TXS/TSX. The engine sits between the control FSM and the memory bus mux.

## Interface
Parameters:
- SP_RESET, 8'hFF, value loaded into S on reset.

Ports:
- ph1  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle and able to accept a command.
- cmd_op  in  2  OP_PUSH, OP_PULL, OP_LOADSP (TXS), OP_NOP.
- cmd_len  in  2  byte count for a push or pull, 1..3; 0 is treated as 1.
- cmd_wdata  in  24  push bytes; byte 0 = [23:16] is written first.
- cmd_sp  in  8  new S value for OP_LOADSP.
- rsp_done  out  1  one-cycle pulse when a command completes.
- rsp_rdata  out  24  pulled bytes; first-pulled byte in [7:0], then [15:8], then [23:16]; unused bytes are 0.
- sp  out  8  current S, used for TSX.
- mem_req  out  1  memory access this cycle.
- mem_we  out  1  write when 1, read when 0.
- mem_addr  out  16  always {8'h01, S-derived byte}.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read data, valid exactly one cycle after a read request.
- sp_fault  out  1  sticky wrap flag; present only with the macro, see Configuration.

## Operation
- States: IDLE, PUSH, PULL_ADDR, PULL_LAST, DONE.
- IDLE: cmd_ready=1. A command is accepted when cmd_valid & cmd_ready; op, len and wdata are latched.
- Accepting OP_LOADSP sets S=cmd_sp, then the engine goes to DONE.
- Accepting OP_NOP goes straight to DONE.
- PUSH, once per byte:
  - Drive mem_req=1, mem_we=1, mem_addr=0x0100|S, mem_wdata=the next byte.
  - Then S ← S−1, wrapping mod 256.
  - After len bytes, go to DONE.
- PULL, once per byte:
  - S ← S+1, wrapping mod 256.
  - Drive the read at 0x0100|(S+1) in the same cycle.
  - Capture mem_rdata in the following cycle.
  - Reads are pipelined: read k+1 is issued in the cycle that read k's data returns.
  - PULL_LAST captures the final byte with no new request. The next state is DONE.
- DONE: rsp_done=1 for one cycle, rsp_rdata valid in that cycle; the next state is IDLE.
- cmd_valid is ignored while cmd_ready=0. Commands are never queued.
- Arithmetic is 8-bit. The high address byte is always 0x01; there is never a carry into page 2 or a borrow into page 0.

## Timing
- Reset values: S=SP_RESET, state IDLE, cmd_ready=1, rsp_done=0, rsp_rdata=0, mem_req=0, mem_we=0, mem_addr=0x0100, mem_wdata=0, sp_fault=0.
- Push of N bytes: accept at cycle 0; writes in cycles 1..N; rsp_done in cycle N+1; cmd_ready again in cycle N+2.
- Pull of N bytes: reads in cycles 1..N; last data captured in cycle N+1; rsp_done in cycle N+2.
- LOADSP/NOP: rsp_done in cycle 1. The new S is visible on `sp` in cycle 1.
- `sp` reflects the registered S, updated the cycle after each byte access.
- Reset asserted mid-command aborts it: the state returns to IDLE with all outputs at reset values on the next edge. No rsp_done is produced, and a partially pushed stack is not rolled back.

## Configuration
- STACK_WRAP_DETECT_EN defined:
  - sp_fault sets when a push decrements S from 0x00 to 0xFF, or a pull increments S from 0xFF to 0x00.
  - It stays set until reset or OP_LOADSP.
  - The wrap itself still occurs.
- Undefined: the sp_fault port is absent and no detection logic is built. All other behaviour is identical.

## Structure
- Shared package stack_pkg holds:
  - the op enum (OP_NOP=0, OP_PUSH=1, OP_PULL=2, OP_LOADSP=3);
  - the state enum;
  - the STACK_PAGE=8'h01 constant.
- No sub-module. The single FSM plus the S register and byte counter form one block.

## Test plan
- Reset with SP_RESET=8'hFF → sp=0xFF, cmd_ready=1, mem_req=0, rsp_done=0.
- LOADSP 0xFD, then PUSH len=3 wdata=0x12_34_56 → writes 0x12@0x01FD, 0x34@0x01FC, 0x56@0x01FB on consecutive cycles; sp=0xFA; rsp_done at cycle 4.
- PULL len=3 from sp=0xFA against a memory model holding the above → reads 0x01FB, 0x01FC, 0x01FD; rsp_rdata=0x12_34_56 ([7:0]=0x56); sp=0xFD; rsp_done at cycle 5.
- LOADSP 0x00, PUSH len=2 0x22_33 → writes 0x22@0x0100 and 0x33@0x01FF, sp=0xFE. With the macro, sp_fault=1; LOADSP then clears it.
- PHA/PLA round-trip (push len=1 0x22, pull len=1) → rsp_rdata=0x000022 and sp restored.
- Reset asserted in the cycle after the second write of a 3-byte push → no third write, no rsp_done, sp=SP_RESET next cycle. cmd_valid held during a busy push is not accepted until cmd_ready=1.
